// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_REQ AXI-Stream masters share one output.
// The grant is held from first beat through tlast; a 2-entry buffer registers the output path.
module axis_packet_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int SRC_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      axis_in_tvalid,
  output logic [NUM_REQ-1:0]                      axis_in_tready,
  input  logic [NUM_REQ-1:0][TDATA_WIDTH-1:0]     axis_in_tdata,
  input  logic [NUM_REQ-1:0]                      axis_in_tlast,
  input  logic [NUM_REQ-1:0][TID_WIDTH-1:0]       axis_in_tid,
  input  logic [NUM_REQ-1:0][TDEST_WIDTH-1:0]     axis_in_tdest,
  output logic                                    axis_out_tvalid,
  input  logic                                    axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
  output logic                                    axis_out_tlast,
  output logic [TID_WIDTH-1:0]                    axis_out_tid,
  output logic [TDEST_WIDTH-1:0]                  axis_out_tdest,
  output logic [SRC_WIDTH-1:0]                    axis_out_tsrc,
  output logic                                    busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
    logic [SRC_WIDTH-1:0]   src;
  } beat_t;

  logic [0:0]           state_q, state_d;
  logic [SRC_WIDTH-1:0] grant_q, grant_d;
  logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 valid_q;
  beat_t                buf_q [2];
  beat_t                buf_d [2];

  logic                 pick_found;
  logic [SRC_WIDTH-1:0] pick_idx;
  int                   scan_idx;
  logic                 in_ready;
  logic                 push;
  logic                 pop;
  logic                 wr_idx;
  logic [SRC_WIDTH-1:0] next_ptr;
  beat_t                in_beat;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!pick_found && axis_in_tvalid[scan_idx[SRC_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[SRC_WIDTH-1:0];
      end
    end
  end

  assign in_ready = (state_q == LOCKED) && (count_q != 2'd2);
  assign push     = in_ready && axis_in_tvalid[grant_q];
  assign pop      = valid_q && axis_out_tready;
  assign next_ptr = (grant_q == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    axis_in_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      axis_in_tready[i] = in_ready && (grant_q == SRC_WIDTH'(i));
    end
  end

  always_comb begin
    in_beat.data = axis_in_tdata[grant_q];
    in_beat.last = axis_in_tlast[grant_q];
    in_beat.id   = axis_in_tid[grant_q];
    in_beat.dest = axis_in_tdest[grant_q];
    in_beat.src  = grant_q;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (push && in_beat.last) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head so the outputs come straight from its flops.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    wr_idx  = count_q[0] && !pop;
    if (pop) buf_d[0] = buf_q[1];
    if (push) buf_d[wr_idx] = in_beat;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != 2'd0);
      buf_q    <= buf_d;
    end
  end

  assign axis_out_tvalid = valid_q;
  assign axis_out_tdata  = buf_q[0].data;
  assign axis_out_tlast  = buf_q[0].last;
  assign axis_out_tid    = buf_q[0].id;
  assign axis_out_tdest  = buf_q[0].dest;
  assign axis_out_tsrc   = buf_q[0].src;
  assign busy            = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter against a queue-based behavioural model.
// Traffic phases vary offer rate, mid-packet stalls and output backpressure; one async reset mid-run.
module tb_axis_packet_arbiter;
  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int IW  = 2;
  localparam int DSW = 4;
  localparam int SW  = 2;
  localparam int NCYC = 3000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           axis_in_tvalid;
  logic [N-1:0]           axis_in_tready;
  logic [N-1:0][DW-1:0]   axis_in_tdata;
  logic [N-1:0]           axis_in_tlast;
  logic [N-1:0][IW-1:0]   axis_in_tid;
  logic [N-1:0][DSW-1:0]  axis_in_tdest;
  logic                   axis_out_tvalid;
  logic                   axis_out_tready;
  logic [DW-1:0]          axis_out_tdata;
  logic                   axis_out_tlast;
  logic [IW-1:0]          axis_out_tid;
  logic [DSW-1:0]         axis_out_tdest;
  logic [SW-1:0]          axis_out_tsrc;
  logic                   busy;

  axis_packet_arbiter #(
    .NUM_REQ(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSW), .SRC_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .axis_out_tsrc(axis_out_tsrc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    int             src;
  } beat_t;

  // Reference model: owner is the requester holding the port (-1 when free).
  beat_t exp_q[$];
  int    m_owner;
  int    m_rr;

  int    g_rem [N];
  bit    g_acc [N];
  int    n_checks;
  int    n_errors;
  int    p_new, p_mid, p_rdy;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    er = '0;
    if (m_owner >= 0 && exp_q.size() < 2) er[m_owner] = 1'b1;
    check("tready", DW'(axis_in_tready), DW'(er));
    check("out_tvalid", DW'(axis_out_tvalid), DW'(exp_q.size() > 0));
    check("busy", DW'(busy), DW'(m_owner >= 0));
    if (exp_q.size() > 0) begin
      check("tdata", axis_out_tdata, exp_q[0].data);
      check("tlast", DW'(axis_out_tlast), DW'(exp_q[0].last));
      check("tid", DW'(axis_out_tid), DW'(exp_q[0].id));
      check("tdest", DW'(axis_out_tdest), DW'(exp_q[0].dest));
      check("tsrc", DW'(axis_out_tsrc), DW'(exp_q[0].src));
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    exp_q.delete();
  endtask

  task automatic gen_reset();
    for (int i = 0; i < N; i++) begin
      g_rem[i] = 0;
      g_acc[i] = 1'b0;
    end
    axis_in_tvalid = '0;
    axis_in_tlast  = '0;
  endtask

  task automatic present(input int i);
    for (int w = 0; w < DW / 32; w++) axis_in_tdata[i][w*32 +: 32] = $urandom;
    axis_in_tlast[i]  = (g_rem[i] == 1);
    axis_in_tvalid[i] = 1'b1;
  endtask

  // Each requester holds a presented beat until it is taken; between beats it may pause.
  task automatic gen_update();
    for (int i = 0; i < N; i++) begin
      if (g_acc[i]) begin
        axis_in_tvalid[i] = 1'b0;
        g_rem[i]--;
      end
      if (!axis_in_tvalid[i]) begin
        if (g_rem[i] > 0) begin
          if (int'($urandom_range(99)) < p_mid) present(i);
        end else if (int'($urandom_range(99)) < p_new) begin
          g_rem[i] = int'($urandom_range(5, 1));
          axis_in_tid[i]   = IW'($urandom);
          axis_in_tdest[i] = DSW'($urandom);
          present(i);
        end
      end
    end
    axis_out_tready = (int'($urandom_range(99)) < p_rdy);
  endtask

  // Advance the model over one rising edge using the inputs now being driven.
  task automatic model_step();
    bit    push, pop, found;
    int    g;
    beat_t b;
    for (int i = 0; i < N; i++) g_acc[i] = 1'b0;
    pop  = (exp_q.size() > 0) && axis_out_tready;
    push = (m_owner >= 0) && (exp_q.size() < 2) && axis_in_tvalid[m_owner];
    if (pop) void'(exp_q.pop_front());
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        g = (m_rr + k) % N;
        if (!found && axis_in_tvalid[g]) begin
          found   = 1'b1;
          m_owner = g;
        end
      end
    end else if (push) begin
      b.data = axis_in_tdata[m_owner];
      b.last = axis_in_tlast[m_owner];
      b.id   = axis_in_tid[m_owner];
      b.dest = axis_in_tdest[m_owner];
      b.src  = m_owner;
      exp_q.push_back(b);
      g_acc[m_owner] = 1'b1;
      if (b.last) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    p_new = 0; p_mid = 0; p_rdy = 0;
    rst = 1'b1;
    axis_out_tready = 1'b0;
    axis_in_tdata   = '0;
    axis_in_tid     = '0;
    axis_in_tdest   = '0;
    gen_reset();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("reset_tsrc", DW'(axis_out_tsrc), '0);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc < 600)       begin p_new = 60;  p_mid = 90;  p_rdy = 90;  end
      else if (cyc < 1200) begin p_new = 100; p_mid = 100; p_rdy = 100; end
      else if (cyc < 2000) begin p_new = 40;  p_mid = 50;  p_rdy = 30;  end
      else if (cyc < 2600) begin p_new = 80;  p_mid = 20;  p_rdy = 70;  end
      else                 begin p_new = 0;   p_mid = 100; p_rdy = 100; end

      @(negedge clk);
      check_outputs();

      if (cyc == 1700) begin
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", DW'(axis_out_tvalid), '0);
        check("async_rst_tready", DW'(axis_in_tready), '0);
        check("async_rst_busy", DW'(busy), '0);
        check("async_rst_tsrc", DW'(axis_out_tsrc), '0);
        model_reset();
        gen_reset();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
      end

      gen_update();
      model_step();
    end

    @(negedge clk);
    check_outputs();
    check("drain_tvalid", DW'(axis_out_tvalid), '0);
    check("drain_busy", DW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
